compression_scheduler: RTL

In-order scheduler between the stream-element ring and the single compression module. It walks the stream elements in strict round-robin order, which preserves record order. It presents the selected element's uncompressed record and byte count to the compressor. When the compressor/return-FIFO path can ingest, it issues a one-cycle data-taken pulse back to that element, then advances.

---
 rtl/compression_scheduler.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/compression_scheduler.sv
// compression_scheduler: strict round-robin scheduler that feeds one stream
// element at a time into the single compression module and pulses a one-cycle
// data-taken strobe back to the element once the compressor can ingest.
// Optional build macro COMPRESSION_SCHEDULER_STATS_EN adds grant/stall counters.
module compression_scheduler #(
  parameter int NUM_STREAM_ELEMENTS    = 4,
  parameter int MAX_UNCOMPRESSED_BYTES = 34,
  parameter int FIFO_MAX_INGEST_BYTES  = 16,
  parameter int CSE_COUNT_WIDTH        = $clog2(MAX_UNCOMPRESSED_BYTES * 8),
  parameter int STALL_LIMIT            = 255
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   i_enable,
  input  logic [NUM_STREAM_ELEMENTS*MAX_UNCOMPRESSED_BYTES*8-1:0] i_use_stream_in,
  input  logic [NUM_STREAM_ELEMENTS*$clog2(MAX_UNCOMPRESSED_BYTES)-1:0] i_use_byte_count_in,
  output logic [NUM_STREAM_ELEMENTS-1:0]                         o_use_data_taken,
  output logic [MAX_UNCOMPRESSED_BYTES*8-1:0]                    o_mux_data_out,
  output logic [7:0]                                             o_mux_byte_count_out,
  input  logic [CSE_COUNT_WIDTH-1:0]                             i_cse_byte_count,
  input  logic                                                   i_cse_shift,
  output logic [$clog2(NUM_STREAM_ELEMENTS)-1:0]                 o_active_index,
  input  logic                                                   i_stall_clear,
`ifdef COMPRESSION_SCHEDULER_STATS_EN
  output logic [31:0]                                            o_grant_count,
  output logic [31:0]                                            o_stall_cycles,
`endif
  output logic                                                   o_stall_timeout
);

  localparam int REC_W   = MAX_UNCOMPRESSED_BYTES * 8;
  localparam int BCW     = $clog2(MAX_UNCOMPRESSED_BYTES);
  localparam int IDX_W   = $clog2(NUM_STREAM_ELEMENTS);
  localparam int STALL_W = ($clog2(STALL_LIMIT + 1) > 8) ? $clog2(STALL_LIMIT + 1) : 8;
  localparam logic [CSE_COUNT_WIDTH-1:0] MAX_INGEST = CSE_COUNT_WIDTH'(FIFO_MAX_INGEST_BYTES);
  localparam logic [STALL_W-1:0]         STALL_MAX  = STALL_W'(STALL_LIMIT);
  localparam logic [STALL_W-1:0]         STALL_PRE  = STALL_W'(STALL_LIMIT - 1);

  typedef enum logic [1:0] {
    ST_WAIT_DATA  = 2'd0,
    ST_WAIT_SPACE = 2'd1,
    ST_TAKE       = 2'd2,
    ST_SETTLE     = 2'd3
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_active_index;
  logic [STALL_W-1:0] r_stall_cnt;
  logic               r_stall_timeout;

  logic [REC_W-1:0]   w_records [NUM_STREAM_ELEMENTS];
  logic [BCW-1:0]     w_counts  [NUM_STREAM_ELEMENTS];
  logic [REC_W-1:0]   w_sel_record;
  logic [BCW-1:0]     w_sel_count;
  logic               w_has_data;
  logic               w_can_ingest;
  logic               w_stall_cycle;

  // Unpack the flat per-element buses and decode the one-hot take pulse
  for (genvar gi = 0; gi < NUM_STREAM_ELEMENTS; gi++) begin : g_elem
    assign w_records[gi]        = i_use_stream_in[gi*REC_W +: REC_W];
    assign w_counts[gi]         = i_use_byte_count_in[gi*BCW +: BCW];
    assign o_use_data_taken[gi] = (r_state == ST_TAKE) && (r_active_index == IDX_W'(gi));
  end

  assign w_sel_record  = w_records[r_active_index];
  assign w_sel_count   = w_counts[r_active_index];
  assign w_has_data    = (w_sel_count != '0);
  assign w_can_ingest  = (i_cse_byte_count == '0) ||
                         ((i_cse_byte_count <= MAX_INGEST) && i_cse_shift);
  assign w_stall_cycle = (r_state == ST_WAIT_SPACE) && !w_can_ingest;

  assign o_mux_data_out       = w_sel_record;
  assign o_mux_byte_count_out = (r_state == ST_WAIT_SPACE) ? 8'(w_sel_count) : 8'd0;
  assign o_active_index       = r_active_index;
  assign o_stall_timeout      = r_stall_timeout;

  // Scheduler FSM plus the saturating stall counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_WAIT_DATA;
      r_active_index  <= '0;
      r_stall_cnt     <= '0;
      r_stall_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_WAIT_DATA: begin
          if (w_has_data && i_enable) r_state <= ST_WAIT_SPACE;
        end
        ST_WAIT_SPACE: begin
          // Losing data or enable abandons the offer; otherwise commit on canIngest
          if (!w_has_data || !i_enable) r_state <= ST_WAIT_DATA;
          else if (w_can_ingest)        r_state <= ST_TAKE;
        end
        ST_TAKE: begin
          r_state        <= ST_SETTLE;
          r_active_index <= r_active_index + IDX_W'(1);
        end
        ST_SETTLE: begin
          r_state <= ST_WAIT_DATA;
        end
        default: r_state <= ST_WAIT_DATA;
      endcase

      // Clear wins over a same-cycle increment or timeout set
      if (i_stall_clear) begin
        r_stall_cnt     <= '0;
        r_stall_timeout <= 1'b0;
      end else begin
        if (r_state == ST_TAKE)                           r_stall_cnt <= '0;
        else if (w_stall_cycle && r_stall_cnt != STALL_MAX) r_stall_cnt <= r_stall_cnt + STALL_W'(1);
        if (w_stall_cycle && r_stall_cnt >= STALL_PRE)    r_stall_timeout <= 1'b1;
      end
    end
  end

`ifdef COMPRESSION_SCHEDULER_STATS_EN
  logic [31:0] r_grant_count;
  logic [31:0] r_stall_cycles;

  assign o_grant_count  = r_grant_count;
  assign o_stall_cycles = r_stall_cycles;

  // Free-running wrap-around statistics, cleared together with the stall flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_count  <= '0;
      r_stall_cycles <= '0;
    end else if (i_stall_clear) begin
      r_grant_count  <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (r_state == ST_TAKE) r_grant_count  <= r_grant_count + 32'd1;
      if (w_stall_cycle)      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
